// File: rtl/opcap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opcap_pkg
//  Description : Shared FSM state codes and command decode for operand capture.
//  Revision    : 1.0  initial release
// ============================================================================
package opcap_pkg;

    localparam logic [1:0] c_COLLECT  = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_RES = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'd0,
        CMD_GO    = 2'd1,
        CMD_CLEAR = 2'd2
    } cmd_e;

    // Codes below num_ops address a slot; num_ops is GO; anything above clears.
    function automatic cmd_e decode_cmd(input int unsigned sel, input int unsigned num_ops);
        if (sel < num_ops)
            return CMD_LOAD;
        else if (sel == num_ops)
            return CMD_GO;
        else
            return CMD_CLEAR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge
//  Description : Rising-edge detector with a configurable history reset value.
//  Revision    : 1.0  initial release
// ============================================================================
module key_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= RESET_VAL;
        else
            r_q <= i_level;
    end

    assign o_rise = i_level & ~r_q;

endmodule
`default_nettype wire

// File: rtl/operand_capture_bank.sv
`default_nettype none
// ============================================================================
//  Module      : operand_capture_bank
//  Description : Captures operands on key commands, issues them to the ALU via
//                ready/valid and holds the returned result for display.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_capture_bank
    import opcap_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 2,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [SEL_W-1:0]         select,
    input  logic [WIDTH-1:0]         dataIn,
    output logic [NUM_OPS*WIDTH-1:0] ops,
    output logic [NUM_OPS-1:0]       op_valid,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    input  logic [WIDTH-1:0]         resultIn,
    input  logic                     result_valid_in,
    output logic [WIDTH-1:0]         resultOut,
    output logic                     done,
    output logic                     busy,
    output logic                     cmd_err
);

    localparam int c_idx_w = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic [1:0]         r_state;
    logic [NUM_OPS-1:0] r_op_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;
    logic               r_cmd_err;

    logic               w_cmd;
    cmd_e               w_kind;
    logic [c_idx_w-1:0] w_idx;
    logic               w_load;
    logic [NUM_OPS-1:0] w_slot_we;
    logic [WIDTH-1:0]   w_slot [NUM_OPS];

    key_edge #(.RESET_VAL(1'b1)) u_key_edge (
        .clk     (clk),
        .rst     (reset),
        .i_level (enable),
        .o_rise  (w_cmd)
    );

    assign w_kind = decode_cmd(32'(select), NUM_OPS);
    assign w_idx  = select[c_idx_w-1:0];
    // Loads are only honoured when not busy, which keeps ops stable during a transaction.
    assign w_load = w_cmd && (w_kind == CMD_LOAD) &&
                    ((r_state == c_COLLECT) || (r_state == c_DONE));

    generate
        for (genvar k = 0; k < NUM_OPS; k++) begin : g_slot
            logic [WIDTH-1:0] r_slot;

            assign w_slot_we[k] = w_load && (w_idx == c_idx_w'(k));

            always_ff @(posedge clk) begin
                if (reset)
                    r_slot <= '0;
                else if (w_slot_we[k])
                    r_slot <= dataIn;
            end

            assign w_slot[k] = r_slot;
        end
    endgenerate

    always_comb begin
        ops = '0;
        for (int k = 0; k < NUM_OPS; k++)
            ops[k*WIDTH +: WIDTH] = w_slot[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_COLLECT;
            r_op_valid <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                c_COLLECT: begin
                    if (w_cmd) begin
                        case (w_kind)
                            CMD_LOAD:  r_op_valid <= r_op_valid | w_slot_we;
                            CMD_GO: begin
                                if (&r_op_valid)
                                    r_state <= c_ISSUE;
                                else
                                    r_cmd_err <= 1'b1;
                            end
                            default:   r_op_valid <= '0;
                        endcase
                    end
                end
                c_ISSUE: begin
                    if (w_cmd)
                        r_cmd_err <= 1'b1;
                    if (issue_ready)
                        r_state <= c_WAIT_RES;
                end
                c_WAIT_RES: begin
                    if (w_cmd)
                        r_cmd_err <= 1'b1;
                    if (result_valid_in) begin
                        r_result <= resultIn;
                        r_done   <= 1'b1;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (w_cmd) begin
                        r_done <= 1'b0;
                        case (w_kind)
                            CMD_LOAD: begin
                                r_op_valid <= w_slot_we;
                                r_state    <= c_COLLECT;
                            end
                            CMD_GO:   r_state <= c_ISSUE;
                            default: begin
                                r_op_valid <= '0;
                                r_state    <= c_COLLECT;
                            end
                        endcase
                    end
                end
                default: r_state <= c_COLLECT;
            endcase
        end
    end

    assign op_valid    = r_op_valid;
    assign issue_valid = (r_state == c_ISSUE);
    assign busy        = (r_state == c_ISSUE) || (r_state == c_WAIT_RES);
    assign resultOut   = r_result;
    assign done        = r_done;
    assign cmd_err     = r_cmd_err;

endmodule
`default_nettype wire
